// File: rtl/vga_pkg.sv
// Shared timing defaults and axis description for the VGA raster generator.
package vga_pkg;

    localparam int unsigned CNT_W = 10;

    // 640x480@60 defaults
    localparam int unsigned H_VIS_DEF  = 640;
    localparam int unsigned H_FP_DEF   = 16;
    localparam int unsigned H_SYNC_DEF = 96;
    localparam int unsigned H_BP_DEF   = 48;
    localparam int unsigned V_VIS_DEF  = 480;
    localparam int unsigned V_FP_DEF   = 10;
    localparam int unsigned V_SYNC_DEF = 2;
    localparam int unsigned V_BP_DEF   = 33;

    typedef struct packed {
        logic [10:0] vis;
        logic [10:0] fp;
        logic [10:0] sync;
        logic [10:0] bp;
    } vga_axis_t;

    localparam vga_axis_t H_AXIS_DEF = '{vis: 11'd640, fp: 11'd16, sync: 11'd96, bp: 11'd48};

    function automatic int unsigned axis_total(vga_axis_t a);
        return 32'(a.vis) + 32'(a.fp) + 32'(a.sync) + 32'(a.bp);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus visible/sync decode of the upcoming position.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter vga_axis_t AXIS = H_AXIS_DEF
) (
    input  logic             vga_clk,
    input  logic             reset,
    input  logic             en,
    input  logic             wrap_in,
    output logic [CNT_W-1:0] pos,
    output logic             at_end,
    output logic             active,
    output logic             in_sync
);

    localparam int unsigned      TOTAL   = axis_total(AXIS);
    localparam int unsigned      SYNC_LO = 32'(AXIS.vis) + 32'(AXIS.fp);
    localparam int unsigned      SYNC_HI = SYNC_LO + 32'(AXIS.sync);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);

    logic [CNT_W-1:0] pos_nxt;

    // Advance on enable, wrapping to zero after the last position.
    always_comb begin
        at_end  = (pos == LAST);
        pos_nxt = pos;
        if (en) begin
            if (!at_end) begin
                pos_nxt = pos + 1'b1;
            end else if (wrap_in) begin
                pos_nxt = '0;
            end
        end
    end

    // Flags describe pos_nxt so the top can register them alongside pos with no skew.
    always_comb begin
        active  = (32'(pos_nxt) < 32'(AXIS.vis));
        in_sync = (32'(pos_nxt) >= SYNC_LO) && (32'(pos_nxt) < SYNC_HI);
    end

    // Position register; reset parks on the last position of the axis.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            pos <= LAST;
        end else begin
            pos <= pos_nxt;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: pixel-tick divider, H/V counters and registered
// blank/sync/pulse outputs aligned with DrawX/DrawY.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_VIS    = H_VIS_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_VIS    = V_VIS_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter logic        SYNC_POL = 1'b0,
    parameter int unsigned CLK_DIV  = 1
) (
    input  logic             vga_clk,
    input  logic             reset,
    output logic [CNT_W-1:0] DrawX,
    output logic [CNT_W-1:0] DrawY,
    output logic             blank,
    output logic             hs,
    output logic             vs,
    output logic             line_start,
    output logic             frame_start,
    output logic [7:0]       frame_count
);

    localparam vga_axis_t H_AXIS = '{vis: 11'(H_VIS), fp: 11'(H_FP), sync: 11'(H_SYNC), bp: 11'(H_BP)};
    localparam vga_axis_t V_AXIS = '{vis: 11'(V_VIS), fp: 11'(V_FP), sync: 11'(V_SYNC), bp: 11'(V_BP)};
    localparam int unsigned H_TOTAL = axis_total(H_AXIS);
    localparam int unsigned V_TOTAL = axis_total(V_AXIS);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_chk
        $error("vga_timing_gen: H_TOTAL/V_TOTAL must fit 10-bit counters");
    end
    if (CLK_DIV < 1 || CLK_DIV > 4) begin : g_div_chk
        $error("vga_timing_gen: CLK_DIV must be 1..4");
    end

    logic [1:0] div;
    logic       tick;
    logic       h_at_end, h_active, h_in_sync;
    logic       v_at_end, v_active, v_in_sync;
    logic       v_en;

    always_comb begin
        tick = (div == 2'(CLK_DIV - 1));
        v_en = tick & h_at_end;
    end

    // Pixel-tick divider: counts 0..CLK_DIV-1.
    always_ff @(posedge vga_clk) begin
        if (reset || tick) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    vga_axis_counter #(.AXIS(H_AXIS)) u_h (
        .vga_clk (vga_clk),
        .reset   (reset),
        .en      (tick),
        .wrap_in (1'b1),
        .pos     (DrawX),
        .at_end  (h_at_end),
        .active  (h_active),
        .in_sync (h_in_sync)
    );

    vga_axis_counter #(.AXIS(V_AXIS)) u_v (
        .vga_clk (vga_clk),
        .reset   (reset),
        .en      (v_en),
        .wrap_in (1'b1),
        .pos     (DrawY),
        .at_end  (v_at_end),
        .active  (v_active),
        .in_sync (v_in_sync)
    );

    // Output registers: decoded from the upcoming position, pulses only on a tick.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            blank       <= 1'b0;
            hs          <= ~SYNC_POL;
            vs          <= ~SYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            blank       <= h_active & v_active;
            hs          <= h_in_sync ? SYNC_POL : ~SYNC_POL;
            vs          <= v_in_sync ? SYNC_POL : ~SYNC_POL;
            line_start  <= tick & h_at_end;
            frame_start <= v_en & v_at_end;
            if (v_en && v_at_end) begin
                frame_count <= frame_count + 1'b1;
            end
        end
    end

endmodule
